// File: rtl/button_debounce_sync.sv
// Push-button conditioner: per-bit two-flop synchronizer, polarity normalization and
// debounce FSM, producing a clean level vector, a 32-bit PIO view and press/release pulses.
module button_debounce_sync #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_level,
  output logic [31:0]      pio_in_port,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  if ((WIDTH < 1) || (WIDTH > 32)) begin : g_bad_width
    $error("button_debounce_sync: WIDTH must be in 1..32");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("button_debounce_sync: DEBOUNCE_CYCLES must be at least 2");
  end

  logic [WIDTH-1:0] norm_s;
  logic [WIDTH-1:0] s1_r;
  logic [WIDTH-1:0] s2_r;
  state_t           state_r [WIDTH];
  state_t           state_s [WIDTH];
  logic [CNT_W-1:0] cnt_r   [WIDTH];
  logic [CNT_W-1:0] cnt_s   [WIDTH];
  logic [WIDTH-1:0] level_r;
  logic [WIDTH-1:0] level_s;
  logic [WIDTH-1:0] press_r;
  logic [WIDTH-1:0] press_s;
  logic [WIDTH-1:0] release_r;
  logic [WIDTH-1:0] release_s;

  // Polarity normalization: 1 always means pressed downstream.
  always_comb begin
    if (ACTIVE_LOW) begin
      norm_s = ~btn_raw;
    end else begin
      norm_s = btn_raw;
    end
  end

  // Two-flop synchronizer; only s2_r feeds the debounce logic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_r <= {WIDTH{1'b0}};
      s2_r <= {WIDTH{1'b0}};
    end else begin
      s1_r <= norm_s;
      s2_r <= s1_r;
    end
  end

  // Per-bit debounce next-state, counter and pulse decode; bits are fully independent.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state_s[i]   = state_r[i];
      cnt_s[i]     = cnt_r[i];
      level_s[i]   = level_r[i];
      press_s[i]   = 1'b0;
      release_s[i] = 1'b0;
      case (state_r[i])
        STABLE_LO: begin
          if (s2_r[i]) begin
            state_s[i] = WAIT_HI;
            cnt_s[i]   = {CNT_W{1'b0}};
          end else begin
            state_s[i] = STABLE_LO;
          end
        end
        WAIT_HI: begin
          if (!s2_r[i]) begin
            state_s[i] = STABLE_LO;
            cnt_s[i]   = {CNT_W{1'b0}};
          end else if (cnt_r[i] == CNT_TERM) begin
            state_s[i] = STABLE_HI;
            level_s[i] = 1'b1;
            press_s[i] = 1'b1;
          end else begin
            cnt_s[i] = cnt_r[i] + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!s2_r[i]) begin
            state_s[i] = WAIT_LO;
            cnt_s[i]   = {CNT_W{1'b0}};
          end else begin
            state_s[i] = STABLE_HI;
          end
        end
        WAIT_LO: begin
          if (s2_r[i]) begin
            state_s[i] = STABLE_HI;
            cnt_s[i]   = {CNT_W{1'b0}};
          end else if (cnt_r[i] == CNT_TERM) begin
            state_s[i]   = STABLE_LO;
            level_s[i]   = 1'b0;
            release_s[i] = 1'b1;
          end else begin
            cnt_s[i] = cnt_r[i] + CNT_W'(1);
          end
        end
        default: begin
          state_s[i] = STABLE_LO;
          cnt_s[i]   = {CNT_W{1'b0}};
          level_s[i] = 1'b0;
        end
      endcase
    end
  end

  // Debounce state, counters, level and pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_r[i] <= STABLE_LO;
        cnt_r[i]   <= {CNT_W{1'b0}};
      end
      level_r   <= {WIDTH{1'b0}};
      press_r   <= {WIDTH{1'b0}};
      release_r <= {WIDTH{1'b0}};
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_r[i] <= state_s[i];
        cnt_r[i]   <= cnt_s[i];
      end
      level_r   <= level_s;
      press_r   <= press_s;
      release_r <= release_s;
    end
  end

  assign btn_level     = level_r;
  assign press_pulse   = press_r;
  assign release_pulse = release_r;
  // Upper PIO bits are tied low; the PIO adds its own read register.
  assign pio_in_port   = 32'(level_r);

endmodule

// File: tb/tb_button_debounce_sync.sv
// Self-checking bench: an active-low and an active-high instance are compared every cycle
// against a sliding-window model, plus hand-computed directed expectations.
module tb_button_debounce_sync;

  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  raw_a;
  logic [3:0]  raw_b;
  logic [3:0]  lvl   [2];
  logic [3:0]  prs   [2];
  logic [3:0]  rel   [2];
  logic [31:0] pio   [2];
  int          tests = 0;
  int          fails = 0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  button_debounce_sync #(.WIDTH(4), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .btn_raw(raw_a), .btn_level(lvl[0]),
    .pio_in_port(pio[0]), .press_pulse(prs[0]), .release_pulse(rel[0]));

  button_debounce_sync #(.WIDTH(4), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .btn_raw(raw_b), .btn_level(lvl[1]),
    .pio_in_port(pio[1]), .press_pulse(prs[1]), .release_pulse(rel[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a level flips to v once the last DC+1 synchronized samples (two cycles old) all equal v.
  logic [3:0] norm [2];
  logic [3:0] hist [2][0:DC+2];
  logic [3:0] all1 [2];
  logic [3:0] any1 [2];
  logic [3:0] m_lvl [2];
  logic [3:0] m_prs [2];
  logic [3:0] m_rel [2];

  assign norm[0] = ~raw_a;
  assign norm[1] = raw_b;

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      all1[d] = 4'hF;
      any1[d] = 4'h0;
      for (int j = 1; j <= DC + 1; j++) begin
        all1[d] = all1[d] & hist[d][j];
        any1[d] = any1[d] | hist[d][j];
      end
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < 2; d++) begin
        for (int j = 0; j <= DC + 2; j++) hist[d][j] <= 4'h0;
        m_lvl[d] <= 4'h0;
        m_prs[d] <= 4'h0;
        m_rel[d] <= 4'h0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        hist[d][0] <= norm[d];
        for (int j = 1; j <= DC + 2; j++) hist[d][j] <= hist[d][j-1];
        m_lvl[d] <= (m_lvl[d] | all1[d]) & any1[d];
        m_prs[d] <= all1[d] & ~m_lvl[d];
        m_rel[d] <= m_lvl[d] & ~any1[d];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_level_a",   {28'h0, lvl[0]}, {28'h0, m_lvl[0]});
      check("cmp_press_a",   {28'h0, prs[0]}, {28'h0, m_prs[0]});
      check("cmp_release_a", {28'h0, rel[0]}, {28'h0, m_rel[0]});
      check("cmp_pio_a",     pio[0],          {28'h0, m_lvl[0]});
      check("cmp_level_b",   {28'h0, lvl[1]}, {28'h0, m_lvl[1]});
      check("cmp_press_b",   {28'h0, prs[1]}, {28'h0, m_prs[1]});
      check("cmp_release_b", {28'h0, rel[1]}, {28'h0, m_rel[1]});
      check("cmp_pio_b",     pio[1],          {28'h0, m_lvl[1]});
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  logic [3:0] seen;

  initial begin
    reset_n = 1'b0;
    raw_a   = 4'hF;
    raw_b   = 4'h0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_level_a", {28'h0, lvl[0]}, 32'h0);
    check("reset_pio_a",   pio[0], 32'h0);
    check("reset_pulses_a", {24'h0, prs[0], rel[0]}, 32'h0);
    #2 reset_n = 1'b1;
    wait_edges(3);

    // Clean press on bit 0 (A) and bit 1 (B, active-high).
    raw_a = 4'hE;
    raw_b = 4'h2;
    wait_edges(6);
    check("press_early_level", {28'h0, lvl[0]}, 32'h0);
    wait_edges(1);
    check("press_level_e7", {28'h0, lvl[0]}, 32'h1);
    check("press_pulse_e7", {28'h0, prs[0]}, 32'h1);
    check("press_pio",      pio[0], 32'h00000001);
    check("pol_level_b",    {28'h0, lvl[1]}, 32'h2);
    check("pol_pio_b",      pio[1], 32'h00000002);
    wait_edges(1);
    check("press_pulse_width", {28'h0, prs[0]}, 32'h0);

    // Release.
    raw_a = 4'hF;
    raw_b = 4'h0;
    wait_edges(6);
    check("rel_early_level", {28'h0, lvl[0]}, 32'h1);
    wait_edges(1);
    check("rel_pulse_e7", {28'h0, rel[0]}, 32'h1);
    check("rel_level",    {28'h0, lvl[0]}, 32'h0);
    check("rel_pio",      pio[0], 32'h0);
    wait_edges(1);
    check("rel_pulse_width", {28'h0, rel[0]}, 32'h0);
    wait_edges(4);

    // Bounce on bit 1: low/high every 2 cycles for 20 cycles, then released.
    seen = 4'h0;
    for (int k = 0; k < 20; k++) begin
      raw_a = ((k % 4) < 2) ? 4'hD : 4'hF;
      wait_edges(1);
      seen = seen | lvl[0] | prs[0] | rel[0];
    end
    raw_a = 4'hF;
    for (int k = 0; k < 10; k++) begin
      wait_edges(1);
      seen = seen | lvl[0] | prs[0] | rel[0];
    end
    check("bounce_no_effect", {28'h0, seen}, 32'h0);

    // Simultaneous press of all bits.
    raw_a = 4'h0;
    wait_edges(6);
    check("simul_early", {28'h0, prs[0]}, 32'h0);
    wait_edges(1);
    check("simul_pulse", {28'h0, prs[0]}, 32'hF);
    check("simul_level", {28'h0, lvl[0]}, 32'hF);
    raw_a = 4'hF;
    wait_edges(12);
    check("simul_released", {28'h0, lvl[0]}, 32'h0);

    // Bit 3 staggered by two cycles.
    raw_a = 4'h8;
    wait_edges(2);
    raw_a = 4'h0;
    wait_edges(4);
    check("stag_early", {28'h0, prs[0]}, 32'h0);
    wait_edges(1);
    check("stag_pulse_lo", {28'h0, prs[0]}, 32'h7);
    wait_edges(1);
    check("stag_gap", {28'h0, prs[0]}, 32'h0);
    wait_edges(1);
    check("stag_pulse_hi", {28'h0, prs[0]}, 32'h8);
    check("stag_level",    {28'h0, lvl[0]}, 32'hF);
    raw_a = 4'hF;
    wait_edges(12);

    // Reset while bit 0 is mid-debounce and bit 2 is already pressed.
    raw_a = 4'hB;
    wait_edges(8);
    check("pre_reset_level", {28'h0, lvl[0]}, 32'h4);
    raw_a = 4'hA;
    wait_edges(5);
    #2 reset_n = 1'b0;
    #1;
    check("mid_reset_level", {28'h0, lvl[0]}, 32'h0);
    check("mid_reset_pio",   pio[0], 32'h0);
    check("mid_reset_pulse", {24'h0, prs[0], rel[0]}, 32'h0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    seen = 4'h0;
    for (int k = 0; k < 6; k++) begin
      wait_edges(1);
      seen = seen | prs[0] | rel[0];
    end
    check("post_reset_quiet", {28'h0, seen}, 32'h0);
    wait_edges(1);
    check("post_reset_press", {28'h0, prs[0]}, 32'h5);
    check("post_reset_level", {28'h0, lvl[0]}, 32'h5);
    wait_edges(1);
    check("post_reset_pulse_width", {28'h0, prs[0]}, 32'h0);

    raw_a = 4'hF;
    wait_edges(10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/button_debounce_sync.md
Name: button_debounce_sync

Overview:
- Conditions raw mechanical push-button inputs from board pins before they reach the 32-bit PIO input port (`in_port`) of the buttons slave on the PCIe/Avalon bus.
- Per bit: two-flop synchronizer, polarity normalization, and a debounce state machine with a cycle counter.
- Outputs: a clean level vector, zero-extended to 32 bits for the PIO, plus one-cycle press and release pulses for local logic such as counters and interrupt sources.

Parameters:
- WIDTH, 4, number of buttons; legal range 1..32.
- DEBOUNCE_CYCLES, 50000, clock cycles the synchronized input must be stable before a level change is accepted (1 ms at 50 MHz); minimum 2.
- ACTIVE_LOW, 1, when 1 a raw input of 0 means pressed (board buttons pull low); when 0 a raw 1 means pressed.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, reset; asynchronous, active-low.
- btn_raw, input, WIDTH, asynchronous button pins.
- btn_level, output, WIDTH, debounced level; 1 = pressed.
- pio_in_port, output, 32, {zeros, btn_level}; drives the buttons PIO `in_port`.
- press_pulse, output, WIDTH, one-cycle pulse per accepted press.
- release_pulse, output, WIDTH, one-cycle pulse per accepted release.

Behaviour:
- Reset (asynchronous, reset_n low):
  - sync stages s1, s2 = 0 (normalized "released");
  - all FSMs in STABLE_LO; counters = 0;
  - btn_level = 0, pio_in_port = 0, press_pulse = 0, release_pulse = 0.
- Normalization: n = ACTIVE_LOW ? ~btn_raw : btn_raw.
  - s1 <= n and s2 <= s1 every clock.
  - Only s2 is used downstream; btn_raw never feeds logic directly.
- Per-bit FSM (fully independent per bit; one counter per bit, width clog2(DEBOUNCE_CYCLES)):
  - STABLE_LO:
    - s2 = 1 -> WAIT_HI, cnt <= 0.
  - WAIT_HI:
    - s2 = 0 -> STABLE_LO, cnt <= 0 (bounce rejected, no pulse);
    - else cnt = DEBOUNCE_CYCLES-1 -> STABLE_HI, btn_level <= 1, press_pulse <= 1;
    - else cnt <= cnt+1.
  - STABLE_HI:
    - s2 = 0 -> WAIT_LO, cnt <= 0.
  - WAIT_LO:
    - mirror of WAIT_HI: s2 = 1 -> STABLE_HI with no pulse;
    - at terminal count -> STABLE_LO, btn_level <= 0, release_pulse <= 1.
- Pulses: registered, high for exactly one cycle, cleared on the following clock unless a new transition occurs (impossible within DEBOUNCE_CYCLES).
- Latency: label E0 as the first rising edge that samples a new stable raw value.
  - btn_level and the pulse update at edge E0+DEBOUNCE_CYCLES+2, i.e. the (DEBOUNCE_CYCLES+3)th edge counting E0.
- Glitches: any glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes btn_level.
- Counter: never wraps; saturation is impossible because it is cleared on every entry to a WAIT state.
- pio_in_port: combinational zero-extension of the btn_level register.
  - Bits [31:WIDTH] are constant 0.
  - The PIO adds its own read register, so read latency is an additional 1 cycle downstream.
- Simultaneous events: bits change and pulse independently in the same cycle; no priority between bits.
- Reset mid-debounce:
  - all state returns to reset values immediately;
  - no pulse is emitted on reset assertion or deassertion.
  - A button held pressed through reset release produces a press_pulse DEBOUNCE_CYCLES+3 edges after reset deassertion (treated as a new press).
- WIDTH > 32: synthesis error (elaboration check).

Test Plan:
- Clean press, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, WIDTH=4: btn_raw 4'hF -> 4'hE, held.
  - btn_level[0] and press_pulse[0] rise at the 7th edge after the change; pulse is 1 cycle wide.
  - pio_in_port = 32'h00000001 afterward.
- Bounce rejection: after reset, btn_raw[1] toggles low/high every 2 cycles for 20 cycles, then settles high (released).
  - btn_level stays 0; no press_pulse or release_pulse.
- Release:
  - from btn_level = 4'h1, drive btn_raw = 4'hF -> release_pulse[0] at edge 7, btn_level = 0, pio_in_port = 0.
- Simultaneous:
  - btn_raw 4'hF -> 4'h0 on one edge -> press_pulse = 4'hF in a single cycle, btn_level = 4'hF;
  - stagger bit 3 by 2 cycles -> its pulse appears 2 cycles later.
- Reset mid-operation:
  - assert reset_n low during WAIT_HI (cnt = 2) -> all outputs 0 immediately;
  - button still held at deassertion -> press_pulse at the 7th edge after release, none at reset edges.
- Polarity: ACTIVE_LOW=0, btn_raw 4'h0 -> 4'h2 -> btn_level = 4'h2 after 7 edges; bits [31:4] of pio_in_port remain 0 throughout.
